// File: rtl/push_cmd_scheduler_if.sv
// Command-bus interface between the button front end and the pixel generator.
// Signals: raw buttons and scan position in; push command, frame tick,
// debounced levels and demo flag out.
// Protocol: there is no valid/ready handshake. push is a level that changes
// only on a frame-tick edge and is held stable until the next tick. The
// consumer samples it once per frame, at its own tick.
interface push_cmd_scheduler_if;
    logic [2:0] btn_raw;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [2:0] push;
    logic       frame_tick;
    logic [2:0] btn_db;
    logic       demo_active;

    // Scheduler side: consumes buttons and scan position, drives the command bus
    modport master (
        input  btn_raw, pixel_x, pixel_y,
        output push, frame_tick, btn_db, demo_active
    );

    // Environment side: drives buttons and scan position, observes the bus
    modport slave (
        output btn_raw, pixel_x, pixel_y,
        input  push, frame_tick, btn_db, demo_active
    );
endinterface

// File: rtl/push_cmd_scheduler.sv
// push_cmd_scheduler: synchronises and debounces three push-buttons, then
// issues at most one one-hot command per frame on push[2:0]. Held buttons
// share the frame slot round-robin.
// Optional feature macro PUSH_DEMO_EN builds an attract/demo sequencer. It
// takes over push after IDLE_FRAMES idle frames. When the macro is undefined,
// the scheduler stays in manual mode and demo_active is tied low.
// demo_active is registered and mirrors the FSM state (1 = DEMO).
module push_cmd_scheduler #(
    parameter int         DB_CYCLES   = 500000,
    parameter logic [9:0] TICK_Y      = 10'd481,
    parameter int         IDLE_FRAMES = 600,
    parameter int         DEMO_HOLD   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    push_cmd_scheduler_if.master  bus
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    // Reject configurations that make the counters degenerate
    if (DB_CYCLES < 2 || IDLE_FRAMES < 2 || DEMO_HOLD < 1) begin : g_cfg_check
        $error("push_cmd_scheduler: invalid DB_CYCLES/IDLE_FRAMES/DEMO_HOLD");
    end

    logic            frame_tick;
    logic [2:0]      sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [2:0]      btn_db_q, btn_db_d;
    logic [2:0]      push_q, push_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]      arb_push;
    logic [1:0]      arb_ptr;

    // Tick is a single pixel of the scan, straight from the sync counters
    assign frame_tick     = (bus.pixel_y == TICK_Y) && (bus.pixel_x == 10'd0);
    assign bus.frame_tick = frame_tick;
    assign bus.push       = push_q;
    assign bus.btn_db     = btn_db_q;

    // Debounce: a level must differ from btn_db for DB_CYCLES edges to be taken
    always_comb begin
        btn_db_d = btn_db_q;
        for (int b = 0; b < 3; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != btn_db_q[b]) begin
                if (db_cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
                    btn_db_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // Round-robin scan of the pre-edge debounced levels, starting after rr_ptr
    always_comb begin
        logic       found;
        logic [1:0] idx;
        arb_push = '0;
        arb_ptr  = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(rr_ptr_q) + k) % 3);
            if (!found && btn_db_q[idx]) begin
                found         = 1'b1;
                arb_push[idx] = 1'b1;
                arb_ptr       = idx;
            end
        end
    end

    // Synchroniser, debounce counters, push register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            btn_db_q <= '0;
            push_q   <= '0;
            rr_ptr_q <= 2'd2;
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q  <= bus.btn_raw;
            sync2_q  <= sync1_q;
            btn_db_q <= btn_db_d;
            push_q   <= push_d;
            rr_ptr_q <= rr_ptr_d;
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
        end
    end

`ifdef PUSH_DEMO_EN
    localparam int IDLE_W = $clog2(IDLE_FRAMES);
    localparam int HOLD_W = (DEMO_HOLD > 1) ? $clog2(DEMO_HOLD) : 1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_DEMO   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        step_q, step_d;
    logic              demo_active_q, demo_active_d;
    logic              idle_last;

    assign idle_last       = (idle_cnt_q == IDLE_W'(IDLE_FRAMES - 1));
    assign bus.demo_active = demo_active_q;

    // Demo script: X, Y, rotate, then one quiet step
    function automatic logic [2:0] script(input logic [1:0] s);
        case (s)
            2'd0:    script = 3'b001;
            2'd1:    script = 3'b010;
            2'd2:    script = 3'b100;
            default: script = 3'b000;
        endcase
    endfunction

    // FSM state and demo counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_MANUAL;
            idle_cnt_q    <= '0;
            hold_q        <= '0;
            step_q        <= '0;
            demo_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            hold_q        <= hold_d;
            step_q        <= step_d;
            demo_active_q <= demo_active_d;
        end
    end

    // Next state: enter demo after enough idle frames, leave on any request
    always_comb begin
        state_d = state_q;
        if (frame_tick) begin
            case (state_q)
                ST_MANUAL: if (btn_db_q == 3'b000 && idle_last) state_d = ST_DEMO;
                ST_DEMO:   if (btn_db_q != 3'b000)              state_d = ST_MANUAL;
                default:   state_d = ST_MANUAL;
            endcase
        end
    end

    // Outputs and counters; exit from demo grants on the same edge
    always_comb begin
        push_d        = push_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        hold_d        = hold_q;
        step_d        = step_q;
        demo_active_d = demo_active_q;
        if (frame_tick) begin
            case (state_q)
                ST_MANUAL: begin
                    push_d   = arb_push;
                    rr_ptr_d = arb_ptr;
                    if (btn_db_q != 3'b000) begin
                        idle_cnt_d = '0;
                    end else if (idle_last) begin
                        hold_d        = '0;
                        step_d        = 2'd0;
                        demo_active_d = 1'b1;
                        push_d        = script(2'd0);
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                ST_DEMO: begin
                    if (btn_db_q != 3'b000) begin
                        push_d        = arb_push;
                        rr_ptr_d      = arb_ptr;
                        demo_active_d = 1'b0;
                        idle_cnt_d    = '0;
                    end else if (hold_q == HOLD_W'(DEMO_HOLD - 1)) begin
                        hold_d = '0;
                        step_d = step_q + 2'd1;
                        push_d = script(step_q + 2'd1);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                        push_d = script(step_q);
                    end
                end
                default: begin
                    push_d = '0;
                end
            endcase
        end
    end
`else
    assign bus.demo_active = 1'b0;

    // Manual only: arbiter result is loaded at every frame tick
    always_comb begin
        push_d   = push_q;
        rr_ptr_d = rr_ptr_q;
        if (frame_tick) begin
            push_d   = arb_push;
            rr_ptr_d = arb_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_push_cmd_scheduler.sv
// Directed testbench for push_cmd_scheduler (DB_CYCLES=4, IDLE_FRAMES=3,
// DEMO_HOLD=2). Demo checks are built when PUSH_DEMO_EN is defined.
module tb_push_cmd_scheduler;

    localparam logic [9:0] TICK_Y = 10'd481;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    push_cmd_scheduler_if bus_if ();

    push_cmd_scheduler #(
        .DB_CYCLES   (4),
        .TICK_Y      (TICK_Y),
        .IDLE_FRAMES (3),
        .DEMO_HOLD   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one clock edge and settle away from it
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame tick edge followed by one ordinary cycle
    task automatic tick();
        bus_if.pixel_y = TICK_Y;
        bus_if.pixel_x = 10'd0;
        step();
        bus_if.pixel_x = 10'd5;
        bus_if.pixel_y = 10'd100;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Safety net against a hung run
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst            = 1'b1;
        bus_if.btn_raw = 3'b000;
        bus_if.pixel_x = 10'd5;
        bus_if.pixel_y = 10'd100;
        step(2);
        rst = 1'b0;

        // Reset state
        check("rst_push", bus_if.push, 3'b000);
        check("rst_btn_db", bus_if.btn_db, 3'b000);
        check("rst_demo", bus_if.demo_active, 1'b0);
        check("tick_idle", bus_if.frame_tick, 1'b0);

        // Frame tick decode, including near misses
        bus_if.pixel_y = TICK_Y; bus_if.pixel_x = 10'd0; #1;
        check("tick_hit", bus_if.frame_tick, 1'b1);
        bus_if.pixel_x = 10'd1; #1;
        check("tick_x1", bus_if.frame_tick, 1'b0);
        bus_if.pixel_y = TICK_Y - 10'd1; bus_if.pixel_x = 10'd0; #1;
        check("tick_y_minus1", bus_if.frame_tick, 1'b0);
        bus_if.pixel_x = 10'd5; bus_if.pixel_y = 10'd100;

        // Debounce: 2-cycle glitch is ignored
        bus_if.btn_raw = 3'b001;
        step(2);
        bus_if.btn_raw = 3'b000;
        step(8);
        check("glitch_db", bus_if.btn_db, 3'b000);

        // Debounce: held level appears exactly 2 sync + 4 edges later
        bus_if.btn_raw = 3'b001;
        step(5);
        check("db_edge5", bus_if.btn_db, 3'b000);
        step(1);
        check("db_edge6", bus_if.btn_db, 3'b001);
        check("no_tick_push", bus_if.push, 3'b000);

        // Latency: grant at the tick, held between ticks
        tick();
        check("lat_grant", bus_if.push, 3'b001);
        step(3);
        check("lat_hold", bus_if.push, 3'b001);
        bus_if.btn_raw = 3'b000;
        step(6);
        check("rel_db", bus_if.btn_db, 3'b000);
        check("rel_hold", bus_if.push, 3'b001);
        tick();
        check("rel_push", bus_if.push, 3'b000);

        // Reset restores rr_ptr=2 before the round-robin run
        bus_if.btn_raw = 3'b111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(6);
        check("rr_db", bus_if.btn_db, 3'b111);

        // Round-robin with all three held
        tick(); check("rr_0", bus_if.push, 3'b001);
        tick(); check("rr_1", bus_if.push, 3'b010);
        tick(); check("rr_2", bus_if.push, 3'b100);
        tick(); check("rr_3", bus_if.push, 3'b001);
        tick(); check("rr_4", bus_if.push, 3'b010);
        tick(); check("rr_5", bus_if.push, 3'b100);

        // rr_ptr=2, only bits 1,2 held: scan 0 then 1
        bus_if.btn_raw = 3'b110;
        step(6);
        check("rr110_db", bus_if.btn_db, 3'b110);
        tick(); check("rr110_0", bus_if.push, 3'b010);
        tick(); check("rr110_1", bus_if.push, 3'b100);

        // Reset mid-frame while push=100
        rst = 1'b1;
        step();
        check("midrst_push", bus_if.push, 3'b000);
        check("midrst_db", bus_if.btn_db, 3'b000);
        check("midrst_demo", bus_if.demo_active, 1'b0);
        rst = 1'b0;
        bus_if.btn_raw = 3'b111;
        step(5);
        check("postrst_db5", bus_if.btn_db, 3'b000);
        step(1);
        check("postrst_db6", bus_if.btn_db, 3'b111);
        tick(); check("postrst_grant", bus_if.push, 3'b001);

        // Go idle
        bus_if.btn_raw = 3'b000;
        step(6);
        check("idle_db", bus_if.btn_db, 3'b000);

`ifdef PUSH_DEMO_EN
        // Two idle ticks stay manual, third enters demo
        tick();
        check("idle1_push", bus_if.push, 3'b000);
        check("idle1_demo", bus_if.demo_active, 1'b0);
        tick();
        check("idle2_push", bus_if.push, 3'b000);
        check("idle2_demo", bus_if.demo_active, 1'b0);
        tick();
        check("demo_entry_push", bus_if.push, 3'b001);
        check("demo_entry_active", bus_if.demo_active, 1'b1);

        // Script steps, each held for two ticks, then wrap
        tick(); check("demo_s0b", bus_if.push, 3'b001);
        tick(); check("demo_s1a", bus_if.push, 3'b010);
        tick(); check("demo_s1b", bus_if.push, 3'b010);
        tick(); check("demo_s2a", bus_if.push, 3'b100);
        tick(); check("demo_s2b", bus_if.push, 3'b100);
        tick(); check("demo_s3a", bus_if.push, 3'b000);
        tick(); check("demo_s3b", bus_if.push, 3'b000);
        tick(); check("demo_wrap", bus_if.push, 3'b001);
        check("demo_still_active", bus_if.demo_active, 1'b1);
`else
        // Without the demo sequencer, long idle leaves push quiet
        tick();
        check("idle_push", bus_if.push, 3'b000);
        for (int f = 0; f < 1000; f++) begin
            tick();
            check("idle_long_push", bus_if.push, 3'b000);
            check("idle_long_demo", bus_if.demo_active, 1'b0);
        end
`endif

        // Request for rotate: granted on the same tick (rr_ptr=0, scan 1,2)
        bus_if.btn_raw = 3'b100;
        step(6);
        check("exit_db", bus_if.btn_db, 3'b100);
        tick();
        check("exit_push", bus_if.push, 3'b100);
        check("exit_demo", bus_if.demo_active, 1'b0);
        tick();
        check("single_repeat", bus_if.push, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
